// File: rtl/alu_acc_seq.sv
// Clocked accumulator ALU: synchronised buttons step an opcode register and launch ops into acc/flags (optional ALU_SAT_EN: saturating ADD/SUB).
// Latency: done pulses 2 cycles after the go pulse for ALU ops, shamt+2 cycles for shifts/rotates (one bit per cycle).
// No backpressure: go is accepted only in IDLE and dropped otherwise; clr aborts any operation at once.
module alu_acc_seq #(
    parameter int WIDTH       = 8,
    parameter int SHAMT_W     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               btn_up,
    input  logic               btn_dn,
    input  logic               btn_go,
    input  logic               btn_clr,
    input  logic               use_acc,
    input  logic               show_flags,
    output logic [2:0]         op_sel,
    output logic               busy,
    output logic               done,
    output logic [3:0]         flags,
    output logic [WIDTH-1:0]   uo
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Button vector order: {clr, go, dn, up}
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]                  hist_q, hist_d;
    logic [3:0]                  btn_pulse;
    logic                        up_p, dn_p, go_p, clr_p;

    state_t             state_q, state_d;
    logic [2:0]         op_sel_q, op_sel_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [WIDTH-1:0]   sh_res;
    logic               sh_out;
    logic               is_shift;
    logic               wb_en;
    logic [WIDTH-1:0]   wb_res;
    logic               wb_c, wb_v;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], {btn_clr, btn_go, btn_dn, btn_up}};
        hist_d    = sync_q[SYNC_STAGES-1];
        btn_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
        up_p      = btn_pulse[0];
        dn_p      = btn_pulse[1];
        go_p      = btn_pulse[2];
        clr_p     = btn_pulse[3];
    end

    always_comb begin
        op_sel_d = op_sel_q;
        if (up_p && !dn_p) begin
            op_sel_d = op_sel_q + 3'd1;
        end else if (dn_p && !up_p) begin
            op_sel_d = op_sel_q - 3'd1;
        end
    end

    assign is_shift = op_q[2] & (op_q[1] | op_q[0]);

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum     = {1'b0, opa_q} + {1'b0, opb_q};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (opa_q[MSB] == opb_q[MSB]) && (alu_res[MSB] != opa_q[MSB]);
            end
            OP_SUB: begin
                sum     = {1'b0, opa_q} + {1'b0, ~opb_q} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[MSB:0];
                alu_c   = sum[WIDTH];
                alu_v   = (opa_q[MSB] != opb_q[MSB]) && (alu_res[MSB] != opa_q[MSB]);
            end
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            default: alu_res = opa_q;
        endcase
`ifdef ALU_SAT_EN
        // Overflow sign always follows operand A for both ADD and SUB
        if (alu_v) begin
            alu_res = opa_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        sh_res = work_q;
        sh_out = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_res = {work_q[MSB-1:0], 1'b0};
                sh_out = work_q[MSB];
            end
            OP_SHR: begin
                sh_res = {1'b0, work_q[MSB:1]};
                sh_out = work_q[0];
            end
            OP_ROR: begin
                sh_res = {work_q[0], work_q[MSB:1]};
                sh_out = work_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (go_p) state_d = ST_EXEC;
                ST_EXEC:  state_d = (is_shift && shamt_q != '0) ? ST_SHIFT : ST_IDLE;
                ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        shamt_d = shamt_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        wb_en   = 1'b0;
        wb_res  = '0;
        wb_c    = 1'b0;
        wb_v    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_p) begin
                    op_d    = op_sel_q;
                    opa_d   = use_acc ? acc_q : a;
                    opb_d   = b;
                    shamt_d = shamt;
                end
            end
            ST_EXEC: begin
                if (!is_shift) begin
                    wb_en  = 1'b1;
                    wb_res = alu_res;
                    wb_c   = alu_c;
                    wb_v   = alu_v;
                end else if (shamt_q == '0) begin
                    wb_en  = 1'b1;
                    wb_res = opa_q;
                end else begin
                    work_d = opa_q;
                    cnt_d  = shamt_q;
                end
            end
            ST_SHIFT: begin
                work_d = sh_res;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    wb_en  = 1'b1;
                    wb_res = sh_res;
                    wb_c   = sh_out;
                end
            end
            default: ;
        endcase
        if (wb_en) begin
            acc_d   = wb_res;
            flags_d = {wb_c, wb_v, wb_res[MSB], (wb_res == '0)};
            done_d  = 1'b1;
        end
        if (clr_p) begin
            acc_d   = '0;
            flags_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hist_q   <= '0;
            state_q  <= ST_IDLE;
            op_sel_q <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            shamt_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            hist_q   <= hist_d;
            state_q  <= state_d;
            op_sel_q <= op_sel_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            shamt_q  <= shamt_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign op_sel = op_sel_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign flags  = flags_q;
    assign uo     = show_flags ? {{(WIDTH-4){1'b0}}, flags_q} : acc_q;

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Parametrised, clocked successor of the team's combinational 8-bit button-driven ALU top.
- Adds button synchronisation with edge detection and an opcode register stepped up/down by buttons.
- Adds a go/clear command path, an accumulator operand mode, iterative multi-cycle shifts and registered C/V/N/Z flags.
- Sits directly behind the board switches/buttons and drives the result/flag display mux.

Parameters:
WIDTH, 8, datapath width in bits; minimum 4.
SHAMT_W, 3, shift-amount width; must equal clog2(WIDTH).
SYNC_STAGES, 2, flip-flop stages in each button synchroniser; minimum 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A (switches)
b  input  WIDTH  operand B (switches)
shamt  input  SHAMT_W  shift/rotate amount
btn_up  input  1  async button: opcode +1
btn_dn  input  1  async button: opcode -1
btn_go  input  1  async button: execute
btn_clr  input  1  async button: clear acc/flags, abort
use_acc  input  1  1 = operand A taken from accumulator
show_flags  input  1  0 = result on uo; 1 = flags on uo
op_sel  output  3  current opcode register
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
flags  output  4  {C,V,N,Z}
uo  output  WIDTH  show_flags ? {zeros,C,V,N,Z} : acc

Behaviour:
- Reset: all outputs 0. Accumulator 0, op_sel 000, state IDLE, synchronisers and edge-detect history 0. Reset is legal mid-operation and aborts it with no writeback.
- Buttons: each passes through SYNC_STAGES flops, then rising-edge detection gives a 1-cycle pulse. Pulse occurs SYNC_STAGES+1 edges after the pin rises. Holding a button gives exactly one pulse.
- Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 ROR.
- up/dn pulses: op_sel +1 / -1 mod 8 (111+1=000, 000-1=111), accepted in any state. Simultaneous up+dn: no change. An in-flight operation uses its latched opcode.
- FSM states: IDLE, EXEC, SHIFT.
- IDLE + go pulse: latch opA (use_acc ? acc : a), b, op_sel, shamt. Next state: EXEC. go outside IDLE is ignored.
- EXEC, op 000-100: next edge computes the result and writes acc and flags; state returns to IDLE.
- EXEC, op 101-111 with shamt=0: writes acc=opA, C=0; state returns to IDLE.
- EXEC, op 101-111 with shamt>0: load working register and counter; next state SHIFT.
- SHIFT: one bit per cycle. Counter reaches 0 after shamt cycles, then the same edge writes acc/flags and returns to IDLE.
- busy = (state != IDLE).
- done = 1 for exactly the cycle after the writeback edge. busy is 0 in that cycle.
- Latency from go pulse to done high: 2 cycles for ALU ops, shamt+2 cycles for shifts.
- Flags, ADD: C = carry out; V = signed overflow.
- Flags, SUB: computed as A+~B+1; C = carry out (1 = no borrow); V = signed overflow.
- Flags, logic ops: C=0, V=0.
- Flags, shifts: C = last bit shifted out (ROR: last bit rotated out); V=0.
- Flags, all ops: N = result[WIDTH-1]; Z = (result==0).
- clr pulse, any state: acc=0, flags=0, state->IDLE, no done pulse; op_sel unchanged.
- clr wins over go in the same cycle.

Optional Feature:
ALU_SAT_EN
- Defined: ADD/SUB saturate to signed limits on overflow (0x7F..F positive, 0x80..0 negative). V still reports the overflow; C is unchanged from the unsaturated sum.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.

Test Plan:
- WIDTH=8, ADD, a=0x7F, b=0x01, go -> done 2 cycles after go pulse; uo=0x80; flags C=0,V=1,N=1,Z=0. With ALU_SAT_EN: uo=0x7F, V=1.
- SUB, a=0x05, b=0x05 -> acc=0x00, C=1,Z=1,V=0,N=0. Then show_flags=1 -> uo=0x09.
- SHL, a=0x81, shamt=1 -> acc=0x02, C=1. busy high 2 cycles. ROR a=0x01, shamt=3 -> acc=0x20, C=0. busy high 4 cycles.
- use_acc=1, acc=0x10, b=0x20, ADD go twice -> acc=0x30, then 0x50. Second go pressed while busy -> ignored.
- op_sel=111 plus btn_up -> 000. btn_dn -> 111. Holding btn_up 100 cycles -> one increment. up+dn same cycle -> unchanged.
- SHR a=0xF0, shamt=7, clr pulse on 3rd SHIFT cycle -> busy drops next cycle; acc=0, flags=0, no done.
- rst_n low mid-shift -> all outputs 0 immediately.
